// File: rtl/wr_port_decoder.sv
// -----------------------------------------------------------------------------
// wr_port_decoder
// Registered multi-port write-enable decoder for the register file.
// Each of NPORTS write ports decodes its select into a one-hot slice of
// 2**SEL_W enables. When several enabled ports target the same register,
// the highest-numbered port (youngest in program order) keeps the write and
// the older ports are suppressed. Cycles in which at least one collision was
// resolved are flagged and counted in a saturating counter.
//
// Optional feature macro: WR_ZERO_REG_MASK_EN
//   When defined, any port selecting ZERO_IDX (the hardwired-zero register)
//   is dropped before arbitration, so writes to it never collide or count.
// -----------------------------------------------------------------------------
module wr_port_decoder #(
    parameter int SEL_W    = 5,
    parameter int NPORTS   = 2,
    parameter int CNT_W    = 8,
    parameter int ZERO_IDX = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NPORTS*SEL_W-1:0]       wr_sel,
    input  logic [NPORTS-1:0]             wr_en,
    input  logic                          stall,
    output logic [NPORTS*(2**SEL_W)-1:0]  we,
    output logic [(2**SEL_W)-1:0]         we_any,
    output logic                          collision,
    output logic [CNT_W-1:0]              collision_cnt
);

    localparam int NOUT = 2**SEL_W;
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [NOUT-1:0]  ONE_HOT_BASE = {{(NOUT-1){1'b0}}, 1'b1};

`ifdef WR_ZERO_REG_MASK_EN
    localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_IDX);
`endif

    // Elaboration-time sanity checks on the configuration.
    if (NPORTS < 1 || NPORTS > 4) begin : g_bad_nports
        $error("wr_port_decoder: NPORTS must be in 1..4");
    end
    if (ZERO_IDX < 0 || ZERO_IDX >= NOUT) begin : g_bad_zero_idx
        $error("wr_port_decoder: ZERO_IDX out of decode range");
    end

    logic [SEL_W-1:0]       sel_s [NPORTS];
    logic [NPORTS-1:0]      req_s;
    logic [NPORTS-1:0]      win_s;
    logic                   coll_s;
    logic [NPORTS*NOUT-1:0] we_next_s;
    logic [NOUT-1:0]        any_next_s;

    logic [NPORTS*NOUT-1:0] we_r;
    logic [NOUT-1:0]        we_any_r;
    logic                   collision_r;
    logic [CNT_W-1:0]       cnt_r;

    // Split the packed select bus per port and form each port's write request.
    always_comb begin
        req_s = '0;
        for (int p = 0; p < NPORTS; p++) begin
            sel_s[p] = wr_sel[p*SEL_W +: SEL_W];
`ifdef WR_ZERO_REG_MASK_EN
            if (sel_s[p] == ZERO_SEL) begin
                req_s[p] = 1'b0;
            end else begin
                req_s[p] = wr_en[p];
            end
`else
            req_s[p] = wr_en[p];
`endif
        end
    end

    // Youngest-port-wins arbitration: an older port loses if any younger
    // requesting port targets the same register.
    always_comb begin
        win_s  = req_s;
        coll_s = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int q = p + 1; q < NPORTS; q++) begin
                if (req_s[p] && req_s[q] && (sel_s[p] == sel_s[q])) begin
                    win_s[p] = 1'b0;
                    coll_s   = 1'b1;
                end else begin
                    coll_s   = coll_s;
                end
            end
        end
    end

    // One-hot decode of the surviving writes and their union.
    always_comb begin
        we_next_s  = '0;
        any_next_s = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (win_s[p]) begin
                we_next_s[p*NOUT +: NOUT] = ONE_HOT_BASE << sel_s[p];
            end else begin
                we_next_s[p*NOUT +: NOUT] = '0;
            end
            any_next_s = any_next_s | we_next_s[p*NOUT +: NOUT];
        end
    end

    // Output register stage with stall hold and saturating collision counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r        <= '0;
            we_any_r    <= '0;
            collision_r <= 1'b0;
            cnt_r       <= '0;
        end else if (!stall) begin
            we_r        <= we_next_s;
            we_any_r    <= any_next_s;
            collision_r <= coll_s;
            if (coll_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            we_r        <= we_r;
            we_any_r    <= we_any_r;
            collision_r <= collision_r;
            cnt_r       <= cnt_r;
        end
    end

    assign we            = we_r;
    assign we_any        = we_any_r;
    assign collision     = collision_r;
    assign collision_cnt = cnt_r;

endmodule

// File: tb/tb_wr_port_decoder.sv
// -----------------------------------------------------------------------------
// tb_wr_port_decoder
// Self-checking bench for wr_port_decoder (NPORTS=2, SEL_W=5). Two instances
// share the same stimulus: one with an 8-bit counter and one with a 3-bit
// counter so that saturation is reachable quickly. A behavioural model built
// from per-register writer counts predicts every output after each edge.
// -----------------------------------------------------------------------------
module tb_wr_port_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [9:0]  wr_sel;
    logic [1:0]  wr_en;

    logic [63:0] we,        we_b;
    logic [31:0] we_any,    we_any_b;
    logic        collision, collision_b;
    logic [7:0]  cnt;
    logic [2:0]  cnt_b;

    int tests = 0;
    int fails = 0;

    logic [63:0] exp_we;
    logic [31:0] exp_any;
    logic        exp_coll;
    int          exp_cnt;
    int          exp_cnt3;

    typedef struct {
        logic [4:0]  s0;
        logic        e0;
        logic [4:0]  s1;
        logic        e1;
        logic        st;
        logic [31:0] any;
        logic        coll;
        int          cnt;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    wr_port_decoder #(.SEL_W(5), .NPORTS(2), .CNT_W(8), .ZERO_IDX(31)) dut (
        .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_en(wr_en), .stall(stall),
        .we(we), .we_any(we_any), .collision(collision), .collision_cnt(cnt)
    );

    wr_port_decoder #(.SEL_W(5), .NPORTS(2), .CNT_W(3), .ZERO_IDX(31)) dut_b (
        .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_en(wr_en), .stall(stall),
        .we(we_b), .we_any(we_any_b), .collision(collision_b), .collision_cnt(cnt_b)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic model_reset();
        exp_we   = '0;
        exp_any  = '0;
        exp_coll = 1'b0;
        exp_cnt  = 0;
        exp_cnt3 = 0;
    endtask

    // Reference model: count writers per register; the last (highest) port
    // to claim a register owns it; two or more writers means a collision.
    task automatic model_capture();
        int   writers [32];
        int   owner   [32];
        int   s;
        logic req;
        logic c;
        if (stall) return;
        for (int i = 0; i < 32; i++) begin
            writers[i] = 0;
            owner[i]   = -1;
        end
        for (int p = 0; p < 2; p++) begin
            s   = int'(wr_sel[p*5 +: 5]);
            req = wr_en[p];
`ifdef WR_ZERO_REG_MASK_EN
            if (s == 31) req = 1'b0;
`endif
            if (req) begin
                writers[s] = writers[s] + 1;
                owner[s]   = p;
            end
        end
        exp_we  = '0;
        exp_any = '0;
        c       = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (owner[i] >= 0) begin
                exp_we[owner[i]*32 + i] = 1'b1;
                exp_any[i]              = 1'b1;
            end
            if (writers[i] >= 2) c = 1'b1;
        end
        exp_coll = c;
        if (c) begin
            if (exp_cnt  < 255) exp_cnt  = exp_cnt + 1;
            if (exp_cnt3 < 7)   exp_cnt3 = exp_cnt3 + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " we"},         we,          exp_we);
        chk({tag, " we_any"},     {32'h0, we_any},   {32'h0, exp_any});
        chk({tag, " collision"},  {63'h0, collision}, {63'h0, exp_coll});
        chk({tag, " cnt"},        {56'h0, cnt},  64'(exp_cnt));
        chk({tag, " cnt3"},       {61'h0, cnt_b}, 64'(exp_cnt3));
        chk({tag, " b we_any"},   {32'h0, we_any_b}, {32'h0, exp_any});
        chk({tag, " b collision"}, {63'h0, collision_b}, {63'h0, exp_coll});
    endtask

    // Drive one cycle of stimulus, let the edge capture it, then compare.
    task automatic cycle(input logic [4:0] s0, input logic e0, input logic [4:0] s1,
                         input logic e1, input logic st, input string tag);
        wr_sel = {s1, s0};
        wr_en  = {e1, e0};
        stall  = st;
        @(posedge clk);
        model_capture();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] exp_slice;
        logic [4:0]  r0, r1;

        tbl[0]  = '{5'd3,  1'b1, 5'd9,  1'b0, 1'b0, 32'h0000_0008, 1'b0, 0};
        tbl[1]  = '{5'd7,  1'b1, 5'd7,  1'b1, 1'b0, 32'h0000_0080, 1'b1, 1};
        tbl[2]  = '{5'd4,  1'b1, 5'd9,  1'b1, 1'b0, 32'h0000_0210, 1'b0, 1};
        tbl[3]  = '{5'd2,  1'b1, 5'd5,  1'b1, 1'b0, 32'h0000_0024, 1'b0, 1};
        tbl[4]  = '{5'd6,  1'b1, 5'd6,  1'b1, 1'b1, 32'h0000_0024, 1'b0, 1};
        tbl[5]  = '{5'd6,  1'b1, 5'd6,  1'b1, 1'b1, 32'h0000_0024, 1'b0, 1};
        tbl[6]  = '{5'd6,  1'b1, 5'd6,  1'b1, 1'b1, 32'h0000_0024, 1'b0, 1};
        tbl[7]  = '{5'd6,  1'b1, 5'd6,  1'b1, 1'b0, 32'h0000_0040, 1'b1, 2};
        tbl[8]  = '{5'd1,  1'b0, 5'd1,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 2};
        tbl[9]  = '{5'd12, 1'b1, 5'd12, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 2};
        tbl[10] = '{5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 32'h0000_0001, 1'b0, 2};

        // Power-on reset
        reset  = 1'b1;
        stall  = 1'b0;
        wr_sel = '0;
        wr_en  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Basic decode, collision and stall table
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].s0, tbl[i].e0, tbl[i].s1, tbl[i].e1, tbl[i].st, "tbl");
            chk("tbl const we_any", {32'h0, we_any}, {32'h0, tbl[i].any});
            chk("tbl const collision", {63'h0, collision}, {63'h0, tbl[i].coll});
            chk("tbl const cnt", {56'h0, cnt}, 64'(tbl[i].cnt));
        end
        chk("tbl port1 slice", we, 64'h0000_0001_0000_0000);

        // Mid-cycle asynchronous reset with nonzero outputs; held across an edge
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        wr_sel = {5'd4, 5'd4};
        wr_en  = 2'b11;
        @(posedge clk);
        #1;
        check_all("reset_hold");
        reset = 1'b0;

        // Sweep port1 select with enable high, then low
        for (int i = 0; i < 32; i++) begin
            cycle(5'd0, 1'b0, 5'(i), 1'b1, 1'b0, "sweep_en");
            exp_slice = 32'd1 << i;
`ifdef WR_ZERO_REG_MASK_EN
            if (i == 31) exp_slice = 32'h0;
`endif
            chk("sweep port1 slice", {32'h0, we[63:32]}, {32'h0, exp_slice});
        end
        for (int i = 0; i < 32; i++) begin
            cycle(5'(i), 1'b0, 5'(i), 1'b0, 1'b0, "sweep_dis");
            chk("sweep disabled we", we, 64'h0);
        end

        // Saturation of both counters
        repeat (300) cycle(5'd7, 1'b1, 5'd7, 1'b1, 1'b0, "sat");
        chk("sat cnt8", {56'h0, cnt}, 64'd255);
        chk("sat cnt3", {61'h0, cnt_b}, 64'd7);
        cycle(5'd7, 1'b1, 5'd7, 1'b1, 1'b0, "sat_hold");
        chk("sat cnt3 hold", {61'h0, cnt_b}, 64'd7);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("sat_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Zero-register handling
        cycle(5'd31, 1'b1, 5'd31, 1'b1, 1'b0, "zero_both");
`ifdef WR_ZERO_REG_MASK_EN
        chk("zero_both collision", {63'h0, collision}, 64'h0);
        chk("zero_both we", we, 64'h0);
`else
        chk("zero_both collision", {63'h0, collision}, 64'h1);
        chk("zero_both we", we, 64'h8000_0000_0000_0000);
`endif
        cycle(5'd31, 1'b1, 5'd30, 1'b1, 1'b0, "zero_one");
`ifdef WR_ZERO_REG_MASK_EN
        chk("zero_one we_any", {32'h0, we_any}, 64'h4000_0000);
`else
        chk("zero_one we_any", {32'h0, we_any}, 64'hC000_0000);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                r0 = 5'($urandom_range(0, 3));
                r1 = 5'($urandom_range(0, 3));
            end else begin
                r0 = 5'($urandom_range(0, 31));
                r1 = 5'($urandom_range(0, 31));
            end
            cycle(r0, 1'($urandom_range(0, 1)), r1, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wr_port_decoder.md
Name: wr_port_decoder

Overview:
- Registered, multi-port write-enable decoder for the register file. Each of NPORTS write ports has its own select and enable, and each is decoded to a one-hot vector of 2**SEL_W enables.
- Resolves same-register collisions between ports and counts them.
- Generalises the single-port 5-to-32 combinational decoder: parametrised width and port count, one pipeline stage with stall, collision arbitration and statistics.
- Sits between writeback/commit and the register file write strobes.

Parameters:
- SEL_W, 5, select width; each port decodes to 2**SEL_W outputs.
- NPORTS, 2, number of independent write ports (1..4).
- CNT_W, 8, width of the saturating collision counter.
- ZERO_IDX, 31, index of the hardwired-zero register; used only with the optional feature.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_sel  input  NPORTS*SEL_W  port p select in bits [p*SEL_W +: SEL_W].
- wr_en  input  NPORTS  per-port write enable.
- stall  input  1  when high, registered outputs and counter hold.
- we  output  NPORTS*2**SEL_W  registered one-hot enable for port p in bits [p*2**SEL_W +: 2**SEL_W].
- we_any  output  2**SEL_W  registered bitwise OR of all ports' we slices.
- collision  output  1  registered pulse: a collision was resolved in the captured cycle.
- collision_cnt  output  CNT_W  saturating count of captured cycles with a collision.

Behaviour:
- Reset: asynchronous, active-high, dominant over stall. we, we_any, collision and collision_cnt all go to 0 immediately; no output glitches to a nonzero value while reset is high.
- Decode (combinational, pre-register):
  - Port p asserts bit wr_sel[p] of its slice iff wr_en[p] = 1.
  - wr_en[p] = 0 gives an all-zero slice regardless of select.
- Collision arbitration:
  - A collision exists when two or more enabled ports select the same index.
  - The highest-numbered enabled port wins (youngest in program order). All lower-numbered ports selecting that index have their slice zeroed.
  - Multiple distinct collisions in one cycle are resolved independently.
  - They count as a single collision cycle: the counter increments by 1, not by the number of collisions.
- Register stage:
  - Latency is exactly 1 cycle. On a rising edge with stall = 0, we, we_any and collision capture the arbitrated values.
  - With stall = 1, all outputs hold their previous values and inputs are ignored. A collision presented during a stall is neither flagged nor counted.
- Counter:
  - collision_cnt increments on each capture edge whose captured collision = 1.
  - It saturates at 2**CNT_W-1 and never wraps.
  - It is cleared only by reset.
- Invariants:
  - Each we slice has at most one bit set.
  - After arbitration no index is set in more than one slice, so we_any has popcount = number of surviving writes.
- NPORTS = 1: collision and collision_cnt are constant 0.

Optional Feature:
- Macro: WR_ZERO_REG_MASK_EN.
- Defined:
  - Any port selecting ZERO_IDX is masked to an all-zero slice before arbitration.
  - Two ports both targeting ZERO_IDX are not a collision and are not counted.
- Undefined: ZERO_IDX is decoded like every other index, and ZERO_IDX is unused.

Test Plan:
1. Reset and basic decode (NPORTS=2, SEL_W=5): assert reset mid-cycle with outputs nonzero → all outputs 0 immediately. Release; drive port0 sel=3 en=1 and port1 en=0 → next edge: we[3]=1, the rest of we is 0, we_any=0x00000008, collision=0.
2. Sweep: for i=0..31, drive port1 sel=i en=1 → one cycle later the port1 slice equals 1<<i. Repeat with en=0 → all slices 0.
3. Collision: port0 sel=7 and port1 sel=7, both enabled → next edge: port0 slice=0, port1 slice=0x80, we_any=0x80, collision=1, collision_cnt=1. Next cycle with distinct sels 4/9 → collision=0, cnt stays 1, we_any=0x210.
4. Stall: capture sel 2/5, then assert stall for 3 cycles while driving colliding sels 6/6 → outputs stay at we_any=0x24, collision=0, cnt unchanged. Deassert stall → collision captured, cnt+1.
5. Saturation: CNT_W=3, drive 10 consecutive colliding unstalled cycles → cnt reaches 7 and holds 7. Then reset → cnt=0.
6. Optional feature (macro defined): both ports sel=31 en=1 → we all 0, collision=0, cnt unchanged. Port0 sel=31, port1 sel=30 → we_any=0x40000000. With the macro undefined, the first stimulus gives collision=1 and port1 bit 31 set.
